// File: rtl/mem_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache for the MEM stage.
// Read hits complete in the request cycle; read misses and all writes go to SRAM and
// hold o_ready low until i_sram_ready. Optional hit/miss statistics: CACHE_STATS_EN.
module mem_cache_controller #(
  parameter int unsigned SETS      = 64,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,            // synchronous, active low
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_sram_rd_en,
  output logic        o_sram_wr_en,
  output logic [31:0] o_sram_address,
  output logic [31:0] o_sram_write_data,
  input  logic [31:0] i_sram_read_data,
  input  logic        i_sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] o_hit_count,
  output logic [15:0] o_miss_count
`endif
);

  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = 17 - IdxW;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrite} state_e;

  state_e r_state, w_state_next;

  logic [31:0]     w_mem_addr;
  logic [IdxW-1:0] w_idx;
  logic [TagW-1:0] w_tag;
  logic            w_unused;

  // Line storage; only valid and LRU bits are cleared by reset.
  logic [SETS-1:0] r_valid [2];
  logic [SETS-1:0] r_lru;
  logic [TagW-1:0] r_tag   [2][SETS];
  logic [31:0]     r_data  [2][SETS];

  logic w_hit0, w_hit1, w_hit, w_hit_way, w_victim;
  logic w_rd_hit, w_fill, w_wr_upd;

  assign w_mem_addr = i_address - BASE_ADDR;
  assign w_idx      = w_mem_addr[2 +: IdxW];
  assign w_tag      = w_mem_addr[18 : 2 + IdxW];
  // Byte offset and bits above the tag do not take part in lookup.
  assign w_unused   = ^{w_mem_addr[31:19], w_mem_addr[1:0]};

  assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1;
  assign w_victim  = r_lru[w_idx];

  assign w_rd_hit = (r_state == StIdle) && i_rd_en && !i_wr_en && w_hit;
  assign w_fill   = (r_state == StRdMiss) && i_sram_ready;
  assign w_wr_upd = (r_state == StWrite) && i_sram_ready && w_hit;

  assign o_sram_address    = i_address;
  assign o_sram_write_data = i_write_data;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the SRAM op always runs to i_sram_ready even if the request drops.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_wr_en)               w_state_next = StWrite;
        else if (i_rd_en && !w_hit) w_state_next = StRdMiss;
      end
      StRdMiss: if (i_sram_ready) w_state_next = StIdle;
      StWrite:  if (i_sram_ready) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Output decode: SRAM strobes from state only, ready/read_data from state and request.
  always_comb begin
    o_ready      = 1'b0;
    o_read_data  = '0;
    o_sram_rd_en = 1'b0;
    o_sram_wr_en = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_wr_en) begin
          o_ready = 1'b0;
        end else if (i_rd_en) begin
          o_ready = w_hit;
          if (w_hit) o_read_data = r_data[w_hit_way][w_idx];
        end else begin
          o_ready = 1'b1;
        end
      end
      StRdMiss: begin
        o_sram_rd_en = 1'b1;
        if (i_sram_ready) begin
          o_ready = 1'b1;
          if (i_rd_en) o_read_data = i_sram_read_data;
        end
      end
      StWrite: begin
        o_sram_wr_en = 1'b1;
        o_ready      = i_sram_ready;
      end
      default: ;
    endcase
  end

  // Valid and LRU bits: set on fill, LRU points away from the way just used.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_lru      <= '0;
    end else if (w_fill) begin
      r_valid[w_victim][w_idx] <= 1'b1;
      r_lru[w_idx]             <= ~w_victim;
    end else if (w_rd_hit || w_wr_upd) begin
      r_lru[w_idx] <= ~w_hit_way;
    end
  end

  // Tag/data arrays: miss fill into the LRU way, write-hit update in place; no reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (w_fill) begin
        r_tag[w_victim][w_idx]  <= w_tag;
        r_data[w_victim][w_idx] <= i_sram_read_data;
      end else if (w_wr_upd) begin
        r_data[w_hit_way][w_idx] <= i_write_data;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count, r_miss_count;

  // Saturating read hit / read miss counters; writes are not counted.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_rd_hit && (r_hit_count != 16'hFFFF))  r_hit_count  <= r_hit_count + 16'd1;
      if (w_fill && (r_miss_count != 16'hFFFF))   r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
